// File: rtl/frame_stream_gen.sv
// Video-style frame generator: stage-0 blanking/active timing plus a two-register output pipeline
// aligned to a synchronous-read pixel memory. Optional test patterns via FRAME_STREAM_GEN_PATTERN_EN.
module frame_stream_gen #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int DW     = 8,
    parameter int HBLANK = 4,
    parameter int VBLANK = 16,
    parameter int CW     = 11
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               continuous,
    input  logic                               stop,
    input  logic [1:0]                         pat_sel,
    output logic [$clog2(IMG_W*IMG_H)-1:0]     mem_addr,
    input  logic [DW-1:0]                      mem_rdata,
    output logic                               fs,
    output logic                               hs,
    output logic [DW-1:0]                      data,
    output logic [CW-1:0]                      hang_cnt_out,
    output logic [CW-1:0]                      lie_cnt_out,
    output logic                               busy,
    output logic [15:0]                        frame_cnt
);

    localparam int AW   = $clog2(IMG_W*IMG_H);
    localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
    localparam int BW   = $clog2(BMAX + 1);
    localparam int CB   = (CW > 3) ? 3 : CW - 1;

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
    localparam logic [BW-1:0] VBL_END  = BW'(VBLANK - 1);
    localparam logic [BW-1:0] HBL_END  = BW'(HBLANK - 1);

    typedef enum logic [1:0] {IDLE, VBL, ACT, HBL} state_t;

    state_t          state_reg;
    logic [CW-1:0]   row_reg;
    logic [CW-1:0]   col_reg;
    logic [BW-1:0]   bcnt_reg;
    logic [AW-1:0]   addr_reg;
    logic [15:0]     frame_cnt_reg;
    logic            stop_pend_reg;

    logic            hs1_reg;
    logic            fs1_reg;
    logic [CW-1:0]   row1_reg;
    logic [CW-1:0]   col1_reg;

    logic            hs2_reg;
    logic            fs2_reg;
    logic [DW-1:0]   data2_reg;
    logic [CW-1:0]   hang2_reg;
    logic [CW-1:0]   lie2_reg;

    logic [DW-1:0]   pix_src;

    // Stage-0 timing generator. The address register simply counts active pixels in
    // row-major order, so it already points at the next row's first pixel during HBL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            row_reg       <= '0;
            col_reg       <= '0;
            bcnt_reg      <= '0;
            addr_reg      <= '0;
            frame_cnt_reg <= '0;
            stop_pend_reg <= 1'b0;
        end else begin
            if (state_reg != IDLE && stop)
                stop_pend_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= VBL;
                        bcnt_reg  <= '0;
                    end
                end
                VBL: begin
                    if (bcnt_reg == VBL_END) begin
                        state_reg <= ACT;
                        row_reg   <= '0;
                        col_reg   <= '0;
                        bcnt_reg  <= '0;
                    end else begin
                        bcnt_reg <= bcnt_reg + BW'(1);
                    end
                end
                ACT: begin
                    addr_reg <= addr_reg + AW'(1);
                    if (col_reg == LAST_COL) begin
                        col_reg <= '0;
                        if (row_reg == LAST_ROW) begin
                            frame_cnt_reg <= frame_cnt_reg + 16'd1;
                            addr_reg      <= '0;
                            row_reg       <= '0;
                            // A stop arriving on the very last pixel still ends the run here.
                            if (continuous && !stop_pend_reg && !stop) begin
                                state_reg <= VBL;
                                bcnt_reg  <= '0;
                            end else begin
                                state_reg     <= IDLE;
                                stop_pend_reg <= 1'b0;
                            end
                        end else begin
                            state_reg <= HBL;
                            bcnt_reg  <= '0;
                        end
                    end else begin
                        col_reg <= col_reg + CW'(1);
                    end
                end
                HBL: begin
                    if (bcnt_reg == HBL_END) begin
                        state_reg <= ACT;
                        row_reg   <= row_reg + CW'(1);
                        bcnt_reg  <= '0;
                    end else begin
                        bcnt_reg <= bcnt_reg + BW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef FRAME_STREAM_GEN_PATTERN_EN
    always_comb begin
        pix_src = mem_rdata;
        case (pat_sel)
            2'd1:    pix_src = DW'(col1_reg);
            2'd2:    pix_src = DW'(row1_reg);
            2'd3:    pix_src = {DW{row1_reg[CB] ^ col1_reg[CB]}};
            default: pix_src = mem_rdata;
        endcase
    end
`else
    logic [1:0] unused_pat_sel;
    assign unused_pat_sel = pat_sel;
    assign pix_src        = mem_rdata;
`endif

    // Stage 1 waits out the memory read latency; stage 2 captures the pixel with its timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs1_reg   <= 1'b0;
            fs1_reg   <= 1'b0;
            row1_reg  <= '0;
            col1_reg  <= '0;
            hs2_reg   <= 1'b0;
            fs2_reg   <= 1'b0;
            data2_reg <= '0;
            hang2_reg <= '0;
            lie2_reg  <= '0;
        end else begin
            hs1_reg   <= (state_reg == ACT);
            fs1_reg   <= (state_reg == ACT) || (state_reg == HBL);
            row1_reg  <= row_reg;
            col1_reg  <= col_reg;
            hs2_reg   <= hs1_reg;
            fs2_reg   <= fs1_reg;
            data2_reg <= hs1_reg ? pix_src  : '0;
            hang2_reg <= hs1_reg ? row1_reg : '0;
            lie2_reg  <= hs1_reg ? col1_reg : '0;
        end
    end

    assign mem_addr     = addr_reg;
    assign fs           = fs2_reg;
    assign hs           = hs2_reg;
    assign data         = data2_reg;
    assign hang_cnt_out = hang2_reg;
    assign lie_cnt_out  = lie2_reg;
    assign frame_cnt    = frame_cnt_reg;
    assign busy         = (state_reg != IDLE) | fs1_reg | fs2_reg;

endmodule

// File: tb/tb_frame_stream_gen.sv
// Directed bench for frame_stream_gen at IMG_W=4, IMG_H=3, HBLANK=2, VBLANK=3 (frame period 19).
module tb_frame_stream_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  pat_sel = 2'd0;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        fs, hs, busy;
    logic [7:0]  data;
    logic [10:0] hang, lie;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;

    frame_stream_gen #(
        .IMG_W(4), .IMG_H(3), .DW(8), .HBLANK(2), .VBLANK(3), .CW(11)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .stop(stop),
        .pat_sel(pat_sel), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .fs(fs), .hs(hs), .data(data), .hang_cnt_out(hang), .lie_cnt_out(lie),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: contents are address + 0x10.
    always @(posedge clk) mem_rdata <= {4'h0, mem_addr} + 8'h10;

    // c counts edges after the one at which start was driven high.
    function automatic bit hs_at(int c);
        if (c < 6 || c > 21) return 1'b0;
        return ((c - 6) % 6) < 4;
    endfunction

    function automatic bit fs_at(int c);
        return (c >= 6) && (c <= 21);
    endfunction

    function automatic int pix_at(int c);
        return ((c - 6) / 6) * 4 + (c - 6) % 6;
    endfunction

    task automatic drive_start;
        @(posedge clk); #1 start = 1'b1;
    endtask

    task automatic test_reset;
        #12;
        if ({hs, fs, busy, data, hang, lie, frame_cnt, mem_addr} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h required 0", {hs, fs, busy, data, hang, lie, frame_cnt, mem_addr});
        end
        checks++;
        #10 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if ({hs, fs, busy, frame_cnt, mem_addr} !== '0) begin
            errors++; $display("FAIL post_reset_idle: got %h required 0", {hs, fs, busy, frame_cnt, mem_addr});
        end
        checks++;
        $display("test_reset done");
    endtask

    task automatic test_single_frame;
        pat_sel = 2'd0; continuous = 1'b0;
        drive_start();
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (hs !== hs_at(c)) begin
                errors++; $display("FAIL single_hs c=%0d: got %b required %b", c, hs, hs_at(c));
            end
            checks++;
            if (fs !== fs_at(c)) begin
                errors++; $display("FAIL single_fs c=%0d: got %b required %b", c, fs, fs_at(c));
            end
            checks++;
            if (busy !== (c <= 21)) begin
                errors++; $display("FAIL single_busy c=%0d: got %b required %b", c, busy, (c <= 21));
            end
            checks++;
            if (!hs_at(c)) begin
                if ({data, hang, lie} !== '0) begin
                    errors++; $display("FAIL single_blank_zero c=%0d: got %h required 0", c, {data, hang, lie});
                end
                checks++;
            end
        end
        exp_frames++;
        if (frame_cnt !== 16'(exp_frames)) begin
            errors++; $display("FAIL single_frame_cnt: got %0d required %0d", frame_cnt, exp_frames);
        end
        checks++;
        if (mem_addr !== 4'd0) begin
            errors++; $display("FAIL single_idle_addr: got %0d required 0", mem_addr);
        end
        checks++;
        $display("test_single_frame done, frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_memory_data;
        int seen = 0;
        logic [7:0] exp_d;
        pat_sel = 2'd0;
        drive_start();
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (hs === 1'b1) seen++;
            if (hs_at(c)) begin
                exp_d = 8'h10 + 8'(pix_at(c));
                if (data !== exp_d || hang !== 11'(pix_at(c) / 4) || lie !== 11'(pix_at(c) % 4)) begin
                    errors++;
                    $display("FAIL mem_pixel c=%0d: got data=%h row=%0d col=%0d required data=%h row=%0d col=%0d",
                             c, data, hang, lie, exp_d, pix_at(c) / 4, pix_at(c) % 4);
                end
                checks++;
            end
        end
        if (seen != 12) begin
            errors++; $display("FAIL mem_pixel_count: got %0d required 12", seen);
        end
        checks++;
        exp_frames++;
        if (frame_cnt !== 16'(exp_frames)) begin
            errors++; $display("FAIL mem_frame_cnt: got %0d required %0d", frame_cnt, exp_frames);
        end
        checks++;
        $display("test_memory_data done, pixels=%0d", seen);
    endtask

    task automatic test_pattern;
        logic [7:0] exp_d;
        for (int sel = 1; sel <= 2; sel++) begin
            pat_sel = 2'(sel);
            drive_start();
            for (int c = 1; c <= 30; c++) begin
                @(posedge clk); #1;
                if (c == 1) start = 1'b0;
                if (hs_at(c)) begin
`ifdef FRAME_STREAM_GEN_PATTERN_EN
                    exp_d = (sel == 1) ? 8'(pix_at(c) % 4) : 8'(pix_at(c) / 4);
`else
                    exp_d = 8'h10 + 8'(pix_at(c));
`endif
                    if (data !== exp_d) begin
                        errors++; $display("FAIL pattern sel=%0d c=%0d: got %h required %h", sel, c, data, exp_d);
                    end
                    checks++;
                end
            end
            exp_frames++;
            $display("test_pattern sel=%0d done", sel);
        end
        pat_sel = 2'd0;
    endtask

    task automatic test_continuous_stop;
        int rises = 0;
        int rise_at[4];
        bit prev_fs = 1'b0;
        continuous = 1'b1;
        drive_start();
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (fs === 1'b1 && !prev_fs) begin
                if (rises < 4) rise_at[rises] = c;
                rises++;
            end
            prev_fs = (fs === 1'b1);
            stop = (c == 32);
        end
        stop = 1'b0;
        continuous = 1'b0;
        if (rises != 2) begin
            errors++; $display("FAIL cont_fs_count: got %0d required 2", rises);
        end
        checks++;
        if (rises >= 2 && (rise_at[0] != 6 || rise_at[1] != 25)) begin
            errors++; $display("FAIL cont_fs_timing: got %0d,%0d required 6,25", rise_at[0], rise_at[1]);
        end
        checks++;
        exp_frames += 2;
        if (frame_cnt !== 16'(exp_frames)) begin
            errors++; $display("FAIL cont_frame_cnt: got %0d required %0d", frame_cnt, exp_frames);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL cont_idle_busy: got %b required 0", busy);
        end
        checks++;
        $display("test_continuous_stop done, fs_rises=%0d frame_cnt=%0d", rises, frame_cnt);
    endtask

    task automatic test_start_ignored;
        int rises = 0;
        int rise_at[4];
        bit prev_fs = 1'b0;
        continuous = 1'b1;
        drive_start();
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (fs === 1'b1 && !prev_fs) begin
                if (rises < 4) rise_at[rises] = c;
                rises++;
            end
            prev_fs = (fs === 1'b1);
            if (c == 22) begin
                if (frame_cnt !== 16'(exp_frames + 1)) begin
                    errors++; $display("FAIL ign_frame_cnt_1: got %0d required %0d", frame_cnt, exp_frames + 1);
                end
                checks++;
            end
            start = (c == 10) || (c == 27);
            stop  = (c == 30);
        end
        start = 1'b0; stop = 1'b0; continuous = 1'b0;
        if (rises != 2 || rise_at[0] != 6 || rise_at[1] != 25) begin
            errors++; $display("FAIL ign_period: got %0d rises first at %0d,%0d required 2 at 6,25",
                               rises, rise_at[0], rise_at[1]);
        end
        checks++;
        exp_frames += 2;
        if (frame_cnt !== 16'(exp_frames)) begin
            errors++; $display("FAIL ign_frame_cnt_2: got %0d required %0d", frame_cnt, exp_frames);
        end
        checks++;
        $display("test_start_ignored done, frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_reset_mid_frame;
        drive_start();
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
        end
        if (hs !== 1'b1 || hang !== 11'd1) begin
            errors++; $display("FAIL rst_mid_precond: got hs=%b row=%0d required hs=1 row=1", hs, hang);
        end
        checks++;
        #2 rst_n = 1'b0;
        #1;
        if ({hs, fs, busy, data, hang, lie, frame_cnt, mem_addr} !== '0) begin
            errors++; $display("FAIL rst_mid_async: got %h required 0", {hs, fs, busy, data, hang, lie, frame_cnt, mem_addr});
        end
        checks++;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        exp_frames = 0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if ({hs, fs, busy, data, hang, lie, frame_cnt, mem_addr} !== '0) begin
                errors++; $display("FAIL rst_mid_quiet c=%0d: got %h required 0", c, {hs, fs, busy, data, hang, lie, frame_cnt, mem_addr});
            end
            checks++;
        end
        $display("test_reset_mid_frame done");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_memory_data();
        test_pattern();
        test_continuous_stop();
        test_start_ignored();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
